// File: rtl/fsa_bram_arbiter.sv
// fsa_bram_arbiter
// ----------------
// Shares the single read port of the FSA line-result block RAM between the
// stream generator and a host readback path.
// - The stream generator has fixed latency and is never stalled.
// - The stream path is purely combinational, so it adds no latency.
// - Host reads (valid/ready, one request in flight) are slotted into cycles
//   where the stream neither reads nor starts a frame.
// - The host response is picked off the shared read data by a one-hot tag
//   that travels a pipeline matched to the RAM read latency.
//
// Optional feature macro: FSA_BRAM_ARB_STAT_EN
// - Defined: builds saturating 16-bit host grant / blocked-cycle counters.
// - Undefined: stat_grants and stat_blocked are tied to zero.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   s_sof, s_en, s_addr    stream frame start / read enable / address
//   s_data                 stream read data (br_data pass-through)
//   h_req_valid/ready/addr host request handshake
//   h_rsp_valid/ready/data host response handshake
//   h_starve               sticky: host waited C_STARVE cycles for a slot
//   br_sof, br_en, br_addr block RAM read request
//   br_data                block RAM read data
//   stat_grants            host grant count
//   stat_blocked           host blocked-cycle count
module fsa_bram_arbiter #(
    parameter int BR_AW    = 12,
    parameter int RD_DW    = 27,
    parameter int C_RD_LAT = 3,
    parameter int C_STARVE = 4095
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_sof,
    input  logic             s_en,
    input  logic [BR_AW-1:0] s_addr,
    output logic [RD_DW-1:0] s_data,
    input  logic             h_req_valid,
    input  logic [BR_AW-1:0] h_req_addr,
    output logic             h_req_ready,
    output logic             h_rsp_valid,
    output logic [RD_DW-1:0] h_rsp_data,
    input  logic             h_rsp_ready,
    output logic             h_starve,
    output logic             br_sof,
    output logic             br_en,
    output logic [BR_AW-1:0] br_addr,
    input  logic [RD_DW-1:0] br_data,
    output logic [15:0]      stat_grants,
    output logic [15:0]      stat_blocked
);

    localparam int CW = (C_STARVE < 1) ? 1 : $clog2(C_STARVE + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(C_STARVE);
    localparam logic [CW-1:0] STARVE_PRE = CW'(C_STARVE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FLIGHT,
        ST_RSP
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [BR_AW-1:0]    h_addr_q;
    logic [RD_DW-1:0]    h_rsp_data_reg;
    logic [C_RD_LAT:1]   tag_reg;
    logic [C_RD_LAT:1]   tag_next;
    logic [CW-1:0]       wait_cnt_reg;
    logic                h_starve_reg;
    logic                h_issue;
    logic                h_blocked;
    logic                h_capture;

    // The host only gets a slot when the stream is silent and no frame starts.
    assign h_issue   = (state_reg == ST_WAIT) & ~s_en & ~s_sof;
    assign h_blocked = (state_reg == ST_WAIT) & ~h_issue;
    // Capture is qualified by the tag alone, so later stream reads that share
    // br_data cannot be mistaken for the host response.
    assign h_capture = (state_reg == ST_FLIGHT) & tag_reg[C_RD_LAT];

    assign br_en   = s_en | h_issue;
    assign br_addr = s_en ? s_addr : h_addr_q;
    assign br_sof  = s_sof;
    assign s_data  = br_data;

    assign h_req_ready = (state_reg == ST_IDLE);
    assign h_rsp_valid = (state_reg == ST_RSP);
    assign h_rsp_data  = h_rsp_data_reg;
    assign h_starve    = h_starve_reg;

    // Tag stage gi is high in the gi-th cycle after the issue; stage C_RD_LAT
    // lines up with the RAM data for that read.
    generate
        for (genvar gi = 1; gi <= C_RD_LAT; gi++) begin : g_tag
            if (gi == 1) begin : g_first
                assign tag_next[gi] = h_issue;
            end else begin : g_shift
                assign tag_next[gi] = tag_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (h_req_valid) state_next = ST_WAIT;
            ST_WAIT:   if (h_issue) state_next = ST_FLIGHT;
            ST_FLIGHT: if (tag_reg[C_RD_LAT]) state_next = ST_RSP;
            ST_RSP:    if (h_rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            h_addr_q       <= '0;
            h_rsp_data_reg <= '0;
            tag_reg        <= '0;
            wait_cnt_reg   <= '0;
            h_starve_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tag_reg   <= tag_next;
            if ((state_reg == ST_IDLE) && h_req_valid) begin
                h_addr_q <= h_req_addr;
            end
            if (h_capture) begin
                h_rsp_data_reg <= br_data;
            end
            if (h_issue) begin
                wait_cnt_reg <= '0;
            end else if (h_blocked && (wait_cnt_reg != STARVE_MAX)) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            // Flag in the same edge the counter reaches the limit.
            if (h_blocked && (wait_cnt_reg >= STARVE_PRE)) begin
                h_starve_reg <= 1'b1;
            end
        end
    end

`ifdef FSA_BRAM_ARB_STAT_EN
    logic [15:0] grants_reg;
    logic [15:0] blocked_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grants_reg  <= '0;
            blocked_reg <= '0;
        end else begin
            if (h_issue && (grants_reg != 16'hFFFF)) begin
                grants_reg <= grants_reg + 16'd1;
            end
            if (h_blocked && (blocked_reg != 16'hFFFF)) begin
                blocked_reg <= blocked_reg + 16'd1;
            end
        end
    end

    assign stat_grants  = grants_reg;
    assign stat_blocked = blocked_reg;
`else
    assign stat_grants  = 16'd0;
    assign stat_blocked = 16'd0;
`endif

endmodule

// File: tb/tb_fsa_bram_arbiter.sv
// Testbench for fsa_bram_arbiter: a latency-L block RAM model returns f(addr)
// for enabled reads and random junk otherwise. A transaction-level model
// predicts accept/issue/response cycles from the slotting rules.
module tb_fsa_bram_arbiter;

    localparam int AW = 12;
    localparam int DW = 27;
    localparam int L = 3;
    localparam int STARVE = 8;
`ifdef FSA_BRAM_ARB_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic s_sof = 1'b0, s_en = 1'b0;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_data;
    logic h_req_valid = 1'b0;
    logic [AW-1:0] h_req_addr = '0;
    logic h_req_ready, h_rsp_valid;
    logic [DW-1:0] h_rsp_data;
    logic h_rsp_ready = 1'b0;
    logic h_starve, br_sof, br_en;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] br_data;
    logic [15:0] stat_grants, stat_blocked;

    always #5 clk = ~clk;

    fsa_bram_arbiter #(.BR_AW(AW), .RD_DW(DW), .C_RD_LAT(L), .C_STARVE(STARVE)) dut (
        .clk(clk), .resetn(resetn), .s_sof(s_sof), .s_en(s_en), .s_addr(s_addr),
        .s_data(s_data), .h_req_valid(h_req_valid), .h_req_addr(h_req_addr),
        .h_req_ready(h_req_ready), .h_rsp_valid(h_rsp_valid), .h_rsp_data(h_rsp_data),
        .h_rsp_ready(h_rsp_ready), .h_starve(h_starve), .br_sof(br_sof), .br_en(br_en),
        .br_addr(br_addr), .br_data(br_data), .stat_grants(stat_grants),
        .stat_blocked(stat_blocked)
    );

    function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
        return {a ^ 12'hA5A, 3'b101, a};
    endfunction

    // Block RAM model
    logic          pe [1:L];
    logic [AW-1:0] pa [1:L];
    logic [DW-1:0] junk;
    initial begin
        for (int k = 1; k <= L; k++) begin pe[k] = 1'b0; pa[k] = '0; end
        junk = '0;
    end
    always @(posedge clk) begin
        pe[1] <= br_en;
        pa[1] <= br_addr;
        for (int k = 2; k <= L; k++) begin pe[k] <= pe[k-1]; pa[k] <= pa[k-1]; end
        junk <= DW'($urandom);
    end
    assign br_data = pe[L] ? f(pa[L]) : junk;

    int total = 0, bad = 0;
    bit sticky = 1'b0;
    int grants_m = 0, blocked_m = 0;

    // Scenario description
    logic [63:0] busy_m, sof_m;
    int req_c, rdy_off, rdy_c;
    logic [AW-1:0] haddr;
    // Observations
    int acc_c, iss_c, n_hen, val_c, drop_c, unstable, rdy_in_rsp, starve_c, s_err;
    logic [AW-1:0] iss_a;
    logic [DW-1:0] v_data;
    logic rdy_at_drop;
    // Expectations
    int e_iss, e_val, e_drop, e_starve, e_blk;
    int due_q[$];
    logic [DW-1:0] dat_q[$];

    function automatic bit bz(input int t);
        return (t >= 0 && t < 64) ? busy_m[t] : 1'b0;
    endfunction
    function automatic bit sf(input int t);
        return (t >= 0 && t < 64) ? sof_m[t] : 1'b0;
    endfunction

    // Host gets the first cycle after acceptance with no stream read and no SOF.
    task automatic model();
        e_iss = -1;
        for (int t = req_c + 1; t < 200; t++) begin
            if (!(bz(t) || sf(t))) begin e_iss = t; break; end
        end
        e_blk    = e_iss - req_c - 1;
        e_val    = e_iss + L + 1;
        rdy_c    = e_val + rdy_off;
        e_drop   = ((rdy_c > e_val) ? rdy_c : e_val) + 1;
        e_starve = sticky ? 0 : ((e_blk >= STARVE) ? req_c + 1 + STARVE : -1);
        if (e_blk >= STARVE) sticky = 1'b1;
        grants_m  += 1;
        blocked_m += e_blk;
    endtask

    // Called just after a rising edge; runs one host transaction to completion.
    task automatic drive();
        acc_c = -1; iss_c = -1; n_hen = 0; val_c = -1; drop_c = -1;
        unstable = 0; rdy_in_rsp = 0; starve_c = -1; s_err = 0;
        iss_a = '0; v_data = '0; rdy_at_drop = 1'b0;
        due_q.delete(); dat_q.delete();
        for (int t = 0; t < 200; t++) begin
            s_en        = bz(t);
            s_sof       = sf(t);
            s_addr      = AW'($urandom);
            h_req_valid = (t >= req_c) && (acc_c < 0);
            h_req_addr  = h_req_valid ? haddr : AW'($urandom);
            h_rsp_ready = (t >= rdy_c);
            @(negedge clk);
            if (h_req_valid && h_req_ready && acc_c < 0) acc_c = t;
            if (br_en && !s_en) begin
                n_hen++;
                if (iss_c < 0) begin iss_c = t; iss_a = br_addr; end
            end
            if (h_rsp_valid) begin
                if (val_c < 0) begin val_c = t; v_data = h_rsp_data; end
                else if (h_rsp_data !== v_data) unstable++;
                if (h_req_ready) rdy_in_rsp++;
            end else if (val_c >= 0 && drop_c < 0) begin
                drop_c = t; rdy_at_drop = h_req_ready;
            end
            if (h_starve && starve_c < 0) starve_c = t;
            if (due_q.size() > 0 && due_q[0] == t) begin
                if (s_data !== dat_q[0]) s_err++;
                void'(due_q.pop_front()); void'(dat_q.pop_front());
            end
            if (s_en) begin due_q.push_back(t + L); dat_q.push_back(f(s_addr)); end
            @(posedge clk); #1;
            if (drop_c >= 0 && t >= 64 + L) break;
        end
        s_en = 1'b0; s_sof = 1'b0; h_req_valid = 1'b0; h_rsp_ready = 1'b0;
        $display("txn addr=%h acc=%0d iss=%0d rsp=%0d data=%h drop=%0d starve=%0d",
                 haddr, acc_c, iss_c, val_c, v_data, drop_c, starve_c);
    endtask

    task automatic test_reset();
        #2;
        total++; if (h_req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got=%b want=1", h_req_ready); end
        total++; if (h_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got=%b want=0", h_rsp_valid); end
        total++; if (h_rsp_data !== '0) begin bad++; $display("FAIL rst_rsp_data: got=%h want=0", h_rsp_data); end
        total++; if (h_starve !== 1'b0) begin bad++; $display("FAIL rst_starve: got=%b want=0", h_starve); end
        total++; if (stat_grants !== 16'd0 || stat_blocked !== 16'd0) begin bad++; $display("FAIL rst_stats: got=%0d/%0d want=0/0", stat_grants, stat_blocked); end
        s_en = 1'b1; s_sof = 1'b1; s_addr = 12'h123;
        #1;
        total++; if (br_en !== 1'b1 || br_addr !== 12'h123 || br_sof !== 1'b1) begin bad++; $display("FAIL rst_passthru: got en=%b addr=%h sof=%b want 1/123/1", br_en, br_addr, br_sof); end
        total++; if (s_data !== br_data) begin bad++; $display("FAIL rst_sdata: got=%h want=%h", s_data, br_data); end
        s_en = 1'b0; s_sof = 1'b0;
        @(posedge clk); #1; resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_stream();
        busy_m = '0; sof_m = '0; req_c = 0; rdy_off = 0; haddr = 12'h005;
        model(); drive();
        total++; if (iss_c !== e_iss) begin bad++; $display("FAIL idle_issue_cyc: got=%0d want=%0d", iss_c, e_iss); end
        total++; if (iss_a !== haddr || n_hen !== 1) begin bad++; $display("FAIL idle_issue_addr: got=%h x%0d want=%h x1", iss_a, n_hen, haddr); end
        total++; if (val_c !== e_val) begin bad++; $display("FAIL idle_rsp_cyc: got=%0d want=%0d", val_c, e_val); end
        total++; if (v_data !== f(haddr)) begin bad++; $display("FAIL idle_rsp_data: got=%h want=%h", v_data, f(haddr)); end
        total++; if (drop_c !== e_drop) begin bad++; $display("FAIL idle_drop_cyc: got=%0d want=%0d", drop_c, e_drop); end
    endtask

    task automatic test_sof_block();
        busy_m = 64'h0000_0000_0000_FBFE; sof_m = 64'h0000_0000_0000_0400;
        req_c = 0; rdy_off = 1; haddr = 12'h2C3;
        model(); drive();
        total++; if (iss_c !== e_iss) begin bad++; $display("FAIL sof_issue_cyc: got=%0d want=%0d", iss_c, e_iss); end
        total++; if (v_data !== f(haddr)) begin bad++; $display("FAIL sof_rsp_data: got=%h want=%h", v_data, f(haddr)); end
        total++; if (s_err !== 0) begin bad++; $display("FAIL sof_stream: got=%0d errors want=0", s_err); end
    endtask

    task automatic test_back_pressure();
        busy_m = '0; sof_m = '0; req_c = 1; rdy_off = 10; haddr = 12'h7E1;
        model(); drive();
        total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable: got=%0d changes want=0", unstable); end
        total++; if (rdy_in_rsp !== 0) begin bad++; $display("FAIL bp_req_ready: got=%0d cycles want=0", rdy_in_rsp); end
        total++; if (drop_c !== e_drop || rdy_at_drop !== 1'b1) begin bad++; $display("FAIL bp_release: got=%0d/%b want=%0d/1", drop_c, rdy_at_drop, e_drop); end
        total++; if (v_data !== f(haddr)) begin bad++; $display("FAIL bp_data: got=%h want=%h", v_data, f(haddr)); end
    endtask

    task automatic test_starvation();
        busy_m = 64'h0000_0000_001F_FFFE; sof_m = '0; req_c = 0; rdy_off = 0; haddr = 12'h0F0;
        model(); drive();
        total++; if (starve_c !== e_starve) begin bad++; $display("FAIL starve_rise: got=%0d want=%0d", starve_c, e_starve); end
        total++; if (h_starve !== 1'b1) begin bad++; $display("FAIL starve_sticky: got=%b want=1", h_starve); end
        total++; if (iss_c !== e_iss) begin bad++; $display("FAIL starve_issue: got=%0d want=%0d", iss_c, e_iss); end
        total++; if (stat_grants !== (STAT ? 16'(grants_m) : 16'd0) || stat_blocked !== (STAT ? 16'(blocked_m) : 16'd0)) begin
            bad++; $display("FAIL starve_stats: got=%0d/%0d want=%0d/%0d", stat_grants, stat_blocked,
                            STAT ? grants_m : 0, STAT ? blocked_m : 0);
        end
    endtask

    task automatic test_saturated();
        busy_m = 64'h0000_00FF_FFFF_FFFF; sof_m = '0; req_c = 2; rdy_off = 0; haddr = 12'h100;
        model(); drive();
        total++; if (acc_c !== 2) begin bad++; $display("FAIL sat_accept: got=%0d want=2", acc_c); end
        total++; if (iss_c !== e_iss) begin bad++; $display("FAIL sat_issue: got=%0d want=%0d", iss_c, e_iss); end
        total++; if (v_data !== f(haddr)) begin bad++; $display("FAIL sat_data: got=%h want=%h", v_data, f(haddr)); end
        total++; if (s_err !== 0) begin bad++; $display("FAIL sat_stream: got=%0d errors want=0", s_err); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            if (n % 2 == 0) busy_m = {$urandom, $urandom} & {$urandom, $urandom};
            else            busy_m = {$urandom, $urandom} | {$urandom, $urandom};
            sof_m   = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            req_c   = int'($urandom_range(0, 10));
            rdy_off = int'($urandom_range(0, 6)) - 2;
            haddr   = AW'($urandom);
            model(); drive();
            total++; if (acc_c !== req_c) begin bad++; $display("FAIL rnd%0d_accept: got=%0d want=%0d", n, acc_c, req_c); end
            total++; if (iss_c !== e_iss || n_hen !== 1) begin bad++; $display("FAIL rnd%0d_issue: got=%0d x%0d want=%0d x1", n, iss_c, n_hen, e_iss); end
            total++; if (val_c !== e_val || v_data !== f(haddr)) begin bad++; $display("FAIL rnd%0d_rsp: got=%0d/%h want=%0d/%h", n, val_c, v_data, e_val, f(haddr)); end
            total++; if (drop_c !== e_drop) begin bad++; $display("FAIL rnd%0d_drop: got=%0d want=%0d", n, drop_c, e_drop); end
            total++; if (s_err !== 0) begin bad++; $display("FAIL rnd%0d_stream: got=%0d errors want=0", n, s_err); end
            total++; if (starve_c !== e_starve) begin bad++; $display("FAIL rnd%0d_starve: got=%0d want=%0d", n, starve_c, e_starve); end
        end
        total++; if (stat_grants !== (STAT ? 16'(grants_m) : 16'd0) || stat_blocked !== (STAT ? 16'(blocked_m) : 16'd0)) begin
            bad++; $display("FAIL rnd_stats: got=%0d/%0d want=%0d/%0d", stat_grants, stat_blocked,
                            STAT ? grants_m : 0, STAT ? blocked_m : 0);
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        stale = 0;
        s_en = 1'b0; s_sof = 1'b0; h_rsp_ready = 1'b0;
        h_req_valid = 1'b1; h_req_addr = 12'h0AA;
        @(posedge clk); #1;
        h_req_valid = 1'b0;
        @(negedge clk);
        total++; if (br_en !== 1'b1 || br_addr !== 12'h0AA) begin bad++; $display("FAIL mid_issue: got en=%b addr=%h want 1/0aa", br_en, br_addr); end
        @(posedge clk); #1;
        resetn = 1'b0;
        sticky = 1'b0; grants_m = 0; blocked_m = 0;
        #1;
        total++; if (h_req_ready !== 1'b1 || h_rsp_valid !== 1'b0 || h_starve !== 1'b0) begin
            bad++; $display("FAIL mid_rst_ctrl: got ready=%b valid=%b starve=%b want 1/0/0", h_req_ready, h_rsp_valid, h_starve);
        end
        total++; if (h_rsp_data !== '0 || stat_grants !== 16'd0 || stat_blocked !== 16'd0) begin
            bad++; $display("FAIL mid_rst_data: got data=%h stats=%0d/%0d want 0/0/0", h_rsp_data, stat_grants, stat_blocked);
        end
        total++; if (br_en !== 1'b0) begin bad++; $display("FAIL mid_rst_bren: got=%b want=0", br_en); end
        repeat (2) @(posedge clk);
        #1; resetn = 1'b1;
        h_rsp_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (h_rsp_valid || !h_req_ready) stale++;
        end
        total++; if (stale !== 0) begin bad++; $display("FAIL mid_stale_rsp: got=%0d cycles want=0", stale); end
        $display("txn reset-midflight addr=0aa stale=%0d", stale);
    endtask

    initial begin
        test_reset();
        test_idle_stream();
        test_sof_block();
        test_back_pressure();
        test_starvation();
        test_saturated();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
